// File: rtl/evm_stack_engine.sv
// rtl/evm_stack_engine.sv - sequential EVM stack-op unit (STOP/POP/PUSH/DUP/SWAP) with gas accounting
// Optional feature macro: EVM_STACK_GAS_LIMIT_EN adds the gas_limit input and out-of-gas check.
module evm_stack_engine #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 1024,
    parameter int GAS_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef EVM_STACK_GAS_LIMIT_EN
    input  logic [GAS_W-1:0]           gas_limit,
`endif
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [7:0]                 opcode,
    input  logic [WIDTH-1:0]           imm,
    output logic                       done,
    output logic [5:0]                 pc_inc,
    output logic [2:0]                 err_code,
    output logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] stack_height,
    output logic [WIDTH-1:0]           top_data,
    output logic [GAS_W-1:0]           gas_used
);
    localparam int HW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SWAP_WR, S_RESP, S_HALTED} state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_opcode;
    logic [WIDTH-1:0] r_imm, r_saved, r_top;
    logic [HW-1:0]    r_height;
    logic [GAS_W-1:0] r_gas;
    logic [2:0]       r_err;
    logic [5:0]       r_pc;
    logic             r_halt;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic             w_is_stop, w_is_pop, w_is_push0, w_is_pushn, w_is_dup, w_is_swap, w_invalid;
    logic [5:0]       w_push_n;
    logic [4:0]       w_dn;
    logic [HW-1:0]    w_dn_h;
    logic             w_underflow, w_overflow, w_oog;
    logic [2:0]       w_err;
    logic [GAS_W-1:0] w_cost;
    logic [GAS_W:0]   w_gas_sum;
    logic [AW-1:0]    w_idx_h, w_idx_top, w_idx_dup, w_idx_swp, w_idx_pop2;
    logic [WIDTH-1:0] w_mask, w_push_data, w_wdata;
    logic [AW-1:0]    w_waddr;
    logic             w_we;

    assign w_is_stop  = (r_opcode == 8'h00);
    assign w_is_pop   = (r_opcode == 8'h50);
    assign w_is_push0 = (r_opcode == 8'h5F);
    assign w_is_pushn = (r_opcode[7:5] == 3'b011);
    assign w_is_dup   = (r_opcode[7:4] == 4'h8);
    assign w_is_swap  = (r_opcode[7:4] == 4'h9);
    assign w_invalid  = !(w_is_stop || w_is_pop || w_is_push0 || w_is_pushn || w_is_dup || w_is_swap);

    assign w_push_n = {1'b0, r_opcode[4:0]} + 6'd1;
    assign w_dn     = {1'b0, r_opcode[3:0]} + 5'd1;
    assign w_dn_h   = HW'(w_dn);

    assign w_underflow = (w_is_pop && (r_height == '0)) ||
                         (w_is_dup && (r_height < w_dn_h)) ||
                         (w_is_swap && (r_height <= w_dn_h));
    assign w_overflow  = (w_is_push0 || w_is_pushn || w_is_dup) && (r_height >= HW'(DEPTH));

    assign w_cost    = (w_is_stop || w_invalid) ? '0 :
                       (w_is_pop || w_is_push0) ? GAS_W'(2) : GAS_W'(3);
    assign w_gas_sum = {1'b0, r_gas} + {1'b0, w_cost};

`ifdef EVM_STACK_GAS_LIMIT_EN
    assign w_oog = (w_gas_sum > {1'b0, gas_limit});
`else
    assign w_oog = 1'b0;
`endif

    assign w_err = w_invalid   ? 3'd3 :
                   w_underflow ? 3'd1 :
                   w_overflow  ? 3'd2 :
                   w_oog       ? 3'd4 : 3'd0;

    // Indices wrap only in cases the checks above already reject.
    assign w_idx_h    = AW'(r_height);
    assign w_idx_top  = AW'(r_height - HW'(1));
    assign w_idx_dup  = AW'(r_height - w_dn_h);
    assign w_idx_swp  = AW'(r_height - HW'(1) - w_dn_h);
    assign w_idx_pop2 = AW'(r_height - HW'(2));

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(w_push_n)) w_mask[b*8 +: 8] = 8'hFF;
        end
    end
    assign w_push_data = w_is_push0 ? '0 : (r_imm & w_mask);

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = w_idx_h;
        w_wdata = w_push_data;
        case (r_state)
            S_IDLE:    if (op_valid) w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_RESP;
                if (w_err == 3'd0) begin
                    if (w_is_push0 || w_is_pushn) begin
                        w_we = 1'b1;
                    end else if (w_is_dup) begin
                        w_we    = 1'b1;
                        w_wdata = r_stack[w_idx_dup];
                    end else if (w_is_swap) begin
                        w_we    = 1'b1;
                        w_waddr = w_idx_top;
                        w_wdata = r_stack[w_idx_swp];
                        w_next  = S_SWAP_WR;
                    end
                end
            end
            S_SWAP_WR: begin
                w_we    = 1'b1;
                w_waddr = w_idx_swp;
                w_wdata = r_saved;
                w_next  = S_RESP;
            end
            S_RESP:    w_next = r_halt ? S_HALTED : S_IDLE;
            S_HALTED:  w_next = S_HALTED;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_imm    <= '0;
            r_saved  <= '0;
            r_top    <= '0;
            r_height <= '0;
            r_gas    <= '0;
            r_err    <= '0;
            r_pc     <= '0;
            r_halt   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (op_valid) begin
                    r_opcode <= opcode;
                    r_imm    <= imm;
                end
                S_EXEC: begin
                    r_err <= w_err;
                    r_pc  <= w_is_pushn ? (w_push_n + 6'd1) : 6'd1;
                    if ((w_err != 3'd0) || w_is_stop) r_halt <= 1'b1;
                    if (w_err == 3'd0) begin
                        r_gas <= w_gas_sum[GAS_W] ? '1 : w_gas_sum[GAS_W-1:0];
                        if (w_is_push0 || w_is_pushn) begin
                            r_height <= r_height + HW'(1);
                            r_top    <= w_push_data;
                        end else if (w_is_dup) begin
                            r_height <= r_height + HW'(1);
                            r_top    <= r_stack[w_idx_dup];
                        end else if (w_is_pop) begin
                            r_height <= r_height - HW'(1);
                            r_top    <= (r_height >= HW'(2)) ? r_stack[w_idx_pop2] : '0;
                        end else if (w_is_swap) begin
                            r_top   <= r_stack[w_idx_swp];
                            r_saved <= r_stack[w_idx_top];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset cycles must not commit a write left pending by an aborted op.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) r_stack[w_waddr] <= w_wdata;
    end

    assign op_ready     = (r_state == S_IDLE);
    assign done         = (r_state == S_RESP);
    assign pc_inc       = r_pc;
    assign err_code     = r_err;
    assign halt         = r_halt;
    assign stack_height = r_height;
    assign top_data     = r_top;
    assign gas_used     = r_gas;
endmodule

// File: tb/tb_evm_stack_engine.sv
// tb/tb_evm_stack_engine.sv - directed and randomized bench for evm_stack_engine against a queue model
module tb_evm_stack_engine;
    localparam int WIDTH = 256;
    localparam int DEPTH = 20;
    localparam int GAS_W = 32;
    localparam int HW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [7:0]       opcode = '0;
    logic [WIDTH-1:0] imm = '0;
    logic             done;
    logic [5:0]       pc_inc;
    logic [2:0]       err_code;
    logic             halt;
    logic [HW-1:0]    stack_height;
    logic [WIDTH-1:0] top_data;
    logic [GAS_W-1:0] gas_used;
`ifdef EVM_STACK_GAS_LIMIT_EN
    logic [GAS_W-1:0] gas_limit = '1;
`endif

    evm_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAS_W(GAS_W)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef EVM_STACK_GAS_LIMIT_EN
        .gas_limit(gas_limit),
`endif
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .imm(imm),
        .done(done), .pc_inc(pc_inc), .err_code(err_code), .halt(halt),
        .stack_height(stack_height), .top_data(top_data), .gas_used(gas_used)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] stk[$];
    longint           m_gas = 0;
    bit               m_halt = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] m_top();
        return (stk.size() > 0) ? stk[stk.size()-1] : '0;
    endfunction

    // Reference: decide error from opcode class and queue depth, then apply the op to the queue.
    task automatic model_op(input logic [7:0] op, input logic [WIDTH-1:0] im,
                            output int e_err, output int e_pc, output int e_lat);
        int n, cost, sz;
        logic [WIDTH-1:0] one, mask, t;
        sz = stk.size(); e_err = 0; e_pc = 1; e_lat = 2; cost = 0; n = 0; one = 1;
        if (op == 8'h00) cost = 0;
        else if (op == 8'h50) begin cost = 2; if (sz < 1) e_err = 1; end
        else if (op == 8'h5F) begin cost = 2; if (sz >= DEPTH) e_err = 2; end
        else if (op >= 8'h60 && op <= 8'h7F) begin
            n = int'(op) - 'h5F; e_pc = 1 + n; cost = 3;
            if (sz >= DEPTH) e_err = 2;
        end else if (op >= 8'h80 && op <= 8'h8F) begin
            n = int'(op) - 'h7F; cost = 3;
            if (sz < n) e_err = 1; else if (sz >= DEPTH) e_err = 2;
        end else if (op >= 8'h90 && op <= 8'h9F) begin
            n = int'(op) - 'h8F; cost = 3;
            if (sz < n + 1) e_err = 1;
        end else e_err = 3;
`ifdef EVM_STACK_GAS_LIMIT_EN
        if (e_err == 0 && (m_gas + cost) > longint'(gas_limit)) e_err = 4;
`endif
        if (e_err != 0 || op == 8'h00) m_halt = 1;
        if (e_err == 0) begin
            m_gas = m_gas + cost;
            if (m_gas > 64'hFFFF_FFFF) m_gas = 64'hFFFF_FFFF;
            if (op == 8'h50) void'(stk.pop_back());
            else if (op == 8'h5F) stk.push_back('0);
            else if (op >= 8'h60 && op <= 8'h7F) begin
                mask = (n * 8 >= WIDTH) ? '1 : ((one << (n * 8)) - one);
                stk.push_back(im & mask);
            end else if (op >= 8'h80 && op <= 8'h8F) stk.push_back(stk[sz-n]);
            else if (op >= 8'h90 && op <= 8'h9F) begin
                t = stk[sz-1]; stk[sz-1] = stk[sz-1-n]; stk[sz-1-n] = t;
                e_lat = 3;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stk.delete(); m_gas = 0; m_halt = 0;
    endtask

    task automatic chk_reset_state();
        chk("rst_op_ready", WIDTH'(op_ready), WIDTH'(1));
        chk("rst_done", WIDTH'(done), WIDTH'(0));
        chk("rst_pc_inc", WIDTH'(pc_inc), WIDTH'(0));
        chk("rst_err", WIDTH'(err_code), WIDTH'(0));
        chk("rst_halt", WIDTH'(halt), WIDTH'(0));
        chk("rst_height", WIDTH'(stack_height), WIDTH'(0));
        chk("rst_top", top_data, WIDTH'(0));
        chk("rst_gas", WIDTH'(gas_used), WIDTH'(0));
    endtask

    task automatic do_op(input logic [7:0] op, input logic [WIDTH-1:0] im);
        int e_err, e_pc, e_lat, cyc, w;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 20) begin @(negedge clk); w++; end
        if (!op_ready) begin
            chk($sformatf("ready_timeout op%02h", op), WIDTH'(op_ready), WIDTH'(1));
            return;
        end
        model_op(op, im, e_err, e_pc, e_lat);
        op_valid = 1'b1; opcode = op; imm = im;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk($sformatf("latency op%02h", op), WIDTH'(cyc), WIDTH'(e_lat));
        chk($sformatf("done op%02h", op), WIDTH'(done), WIDTH'(1));
        chk($sformatf("err op%02h", op), WIDTH'(err_code), WIDTH'(e_err));
        chk($sformatf("pc_inc op%02h", op), WIDTH'(pc_inc), WIDTH'(e_pc));
        chk($sformatf("halt op%02h", op), WIDTH'(halt), WIDTH'(m_halt));
        chk($sformatf("height op%02h", op), WIDTH'(stack_height), WIDTH'(stk.size()));
        chk($sformatf("top op%02h", op), top_data, m_top());
        chk($sformatf("gas op%02h", op), WIDTH'(gas_used), WIDTH'(m_gas));
        @(posedge clk); #1;
        chk($sformatf("done_pulse op%02h", op), WIDTH'(done), WIDTH'(0));
        chk($sformatf("ready_after op%02h", op), WIDTH'(op_ready), WIDTH'(!m_halt));
    endtask

    task automatic expect_rejected();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_valid = 1'b1; opcode = 8'h5F; imm = '0;
            @(posedge clk); #1;
            chk("halted_ready", WIDTH'(op_ready), WIDTH'(0));
            chk("halted_done", WIDTH'(done), WIDTH'(0));
        end
        op_valid = 1'b0;
        chk("halted_height", WIDTH'(stack_height), WIDTH'(stk.size()));
        chk("halted_gas", WIDTH'(gas_used), WIDTH'(m_gas));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a_word;
        int r;
        logic [7:0] op;

        do_reset();
        chk_reset_state();

        do_op(8'h60, WIDTH'(12'h1AB));

        do_reset();
        a_word = '1;
        a_word = a_word / 15 * 10;
        do_op(8'h7F, a_word);
        do_op(8'h60, WIDTH'(8'h05));
        do_op(8'h90, '0);
        chk("swap_top", top_data, a_word);
        do_op(8'h50, '0);
        chk("swap_bottom", top_data, WIDTH'(8'h05));

        do_reset();
        do_op(8'h50, '0);
        expect_rejected();

        do_reset();
        for (int i = 0; i < DEPTH; i++) do_op(8'h60 + 8'($urandom_range(0, 31)), rnd_word());
        do_op(8'h80, '0);
        chk("ovf_height", WIDTH'(stack_height), WIDTH'(DEPTH));
        expect_rejected();

        do_reset();
        do_op(8'h01, '0);
        do_reset();
        do_op(8'h00, '0);

        do_reset();
        @(negedge clk);
        op_valid = 1'b1; opcode = 8'h60; imm = WIDTH'(8'h77);
        @(posedge clk); #1;
        op_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_done", WIDTH'(done), WIDTH'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        stk.delete(); m_gas = 0; m_halt = 0;
        chk_reset_state();

`ifdef EVM_STACK_GAS_LIMIT_EN
        do_reset();
        gas_limit = 32'd5;
        do_op(8'h60, WIDTH'(8'h11));
        do_op(8'h60, WIDTH'(8'h22));
        gas_limit = '1;
`endif

        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      op = 8'h60 + 8'($urandom_range(0, 31));
            else if (r < 40) op = 8'h5F;
            else if (r < 55) op = 8'h50;
            else if (r < 75) op = 8'h80 + 8'($urandom_range(0, 15));
            else if (r < 95) op = 8'h90 + 8'($urandom_range(0, 15));
            else if (r < 97) op = 8'h00;
            else             op = 8'h01 + 8'($urandom_range(0, 'h4E));
            do_op(op, rnd_word());
            if (m_halt) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
